// File: rtl/cc_apb_master.sv
// APB master bridging a single-outstanding request/response channel onto an APB bus.
// Includes a wait-state timeout and a saturating error counter.
module cc_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [11:0] req_addr_i,
  input  logic        req_write_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic [11:0] paddr_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i,
  output logic [7:0]  err_cnt_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam bit         TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TimeoutLast = TimeoutEn ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

  logic [1:0]  state_q, state_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic [11:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;

  // The count of wait cycles already seen; abort on the wait cycle that would reach the limit.
  logic timeout_hit;
  assign timeout_hit = TimeoutEn && (tcnt_q == TimeoutLast);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    tcnt_d      = tcnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d  = StSetup;
          psel_d   = 1'b1;
          paddr_d  = req_addr_i;
          pwrite_d = req_write_i;
          pwdata_d = req_wdata_i;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        tcnt_d    = 8'd0;
      end
      StAccess: begin
        if (pready_i) begin
          state_d     = StResp;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'd0 : prdata_i;
          rsp_err_d   = pslverr_i;
        end else if (timeout_hit) begin
          state_d     = StResp;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
        end else if (tcnt_q != 8'hff) begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          if (rsp_err_q && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= 12'd0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 8'd0;
      tcnt_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Gated by rst so the request channel reads not-ready throughout reset.
  assign req_ready_o = (state_q == StIdle) && !rst;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_cc_apb_master.sv
// Self-checking bench for cc_apb_master: bench acts as APB slave and response sink,
// comparing against a transaction-level reference model.
module tb_cc_apb_master;

  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [11:0] req_addr_i = '0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        psel_o;
  logic        penable_o;
  logic [11:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic        pready_i = 1'b0;
  logic [31:0] prdata_i = '0;
  logic        pslverr_i = 1'b0;
  logic [7:0]  err_cnt_o;

  int n_cmp = 0;
  int n_fail = 0;
  int model_err_cnt = 0;

  cc_apb_master #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .paddr_o    (paddr_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pready_i   (pready_i),
    .prdata_i   (prdata_i),
    .pslverr_i  (pslverr_i),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transaction-level expectation: timeout when the slave stalls for Timeout or more cycles.
  function automatic void model_rsp(input logic wr, input int waits, input logic slverr,
                                    input logic [31:0] rdata, output logic [31:0] exp_rdata,
                                    output logic exp_err, output int n_acc);
    if (Timeout != 0 && waits >= int'(Timeout)) begin
      exp_rdata = 32'd0;
      exp_err   = 1'b1;
      n_acc     = int'(Timeout);
    end else begin
      exp_rdata = wr ? 32'd0 : rdata;
      exp_err   = slverr;
      n_acc     = waits + 1;
    end
  endfunction

  task automatic drive_junk_req();
    req_valid_i = 1'($urandom);
    req_addr_i  = 12'($urandom);
    req_write_i = 1'($urandom);
    req_wdata_i = $urandom;
  endtask

  task automatic drive_junk_apb();
    pready_i  = 1'($urandom);
    pslverr_i = 1'($urandom);
    prdata_i  = $urandom;
  endtask

  // One full transaction from an IDLE negedge back to the IDLE negedge after the handshake.
  task automatic run_txn(input string tag, input logic [11:0] addr, input logic wr,
                         input logic [31:0] wdata, input int waits, input logic slverr,
                         input logic [31:0] rdata, input int rsp_delay);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          n_acc;
    model_rsp(wr, waits, slverr, rdata, exp_rdata, exp_err, n_acc);

    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b want 1", tag, req_ready_o);
    end
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wdata;
    drive_junk_apb();
    @(negedge clk);

    n_cmp++;
    if ({psel_o, penable_o, req_ready_o, rsp_valid_o, paddr_o, pwrite_o, pwdata_o} !==
        {4'b1000, addr, wr, wdata}) begin
      n_fail++;
      $display("FAIL %s setup: got sel%b en%b rdy%b v%b a%h w%b d%h want a%h w%b d%h", tag,
               psel_o, penable_o, req_ready_o, rsp_valid_o, paddr_o, pwrite_o, pwdata_o,
               addr, wr, wdata);
    end
    drive_junk_req();
    drive_junk_apb();
    @(negedge clk);

    for (int k = 1; k <= n_acc; k++) begin
      n_cmp++;
      if ({psel_o, penable_o, rsp_valid_o, paddr_o, pwrite_o, pwdata_o} !==
          {3'b110, addr, wr, wdata}) begin
        n_fail++;
        $display("FAIL %s access%0d: got sel%b en%b v%b a%h w%b d%h want a%h w%b d%h", tag, k,
                 psel_o, penable_o, rsp_valid_o, paddr_o, pwrite_o, pwdata_o, addr, wr, wdata);
      end
      pready_i  = (k == waits + 1);
      pslverr_i = pready_i ? slverr : 1'($urandom);
      prdata_i  = pready_i ? rdata : $urandom;
      drive_junk_req();
      @(negedge clk);
    end

    for (int d = 0; d <= rsp_delay; d++) begin
      n_cmp++;
      if ({psel_o, penable_o, req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o} !==
          {4'b0001, exp_rdata, exp_err}) begin
        n_fail++;
        $display("FAIL %s resp%0d: got sel%b en%b rdy%b v%b rd%h e%b want rd%h e%b", tag, d,
                 psel_o, penable_o, req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
                 exp_rdata, exp_err);
      end
      drive_junk_apb();
      drive_junk_req();
      rsp_ready_i = (d == rsp_delay);
      if (d == rsp_delay) req_valid_i = 1'b0;
      @(negedge clk);
    end
    rsp_ready_i = 1'b0;
    if (exp_err && model_err_cnt < 255) model_err_cnt++;

    n_cmp++;
    if ({rsp_valid_o, req_ready_o, psel_o, err_cnt_o} !== {3'b010, 8'(model_err_cnt)}) begin
      n_fail++;
      $display("FAIL %s done: got v%b rdy%b sel%b cnt%0d want v0 rdy1 sel0 cnt%0d", tag,
               rsp_valid_o, req_ready_o, psel_o, err_cnt_o, model_err_cnt);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({req_ready_o, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, rsp_valid_o,
         rsp_rdata_o, rsp_err_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy%b sel%b en%b a%h w%b d%h v%b rd%h e%b cnt%0d want 0",
               req_ready_o, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, rsp_valid_o,
               rsp_rdata_o, rsp_err_o, err_cnt_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    run_txn("read_basic", 12'h000, 1'b0, 32'h0, 0, 1'b0, 32'h0001_0101, 0);
  endtask

  task automatic test_write_wait_err();
    run_txn("write_wait_err", 12'h004, 1'b1, 32'hDEAD_BEEF, 3, 1'b1, 32'h1234_5678, 0);
  endtask

  task automatic test_timeout();
    run_txn("timeout_abort", 12'h010, 1'b0, 32'h0, 16, 1'b0, 32'hCAFE_0001, 0);
    run_txn("timeout_race", 12'h014, 1'b0, 32'h0, 15, 1'b0, 32'hCAFE_0002, 0);
    run_txn("timeout_long", 12'h018, 1'b1, 32'h5555_AAAA, 40, 1'b0, 32'h0, 1);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", 12'h020, 1'b0, 32'h0, 1, 1'b0, 32'hA5A5_5A5A, 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_txn("back_to_back", 12'(i * 4), 1'(i), $urandom, 0, 1'b0, $urandom, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_txn("random", 12'($urandom), 1'($urandom), $urandom, $urandom_range(0, 20),
              1'($urandom), $urandom, $urandom_range(0, 3));
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1;
    req_addr_i  = 12'h0AB;
    req_write_i = 1'b1;
    req_wdata_i = 32'h1357_9BDF;
    pready_i    = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready_o, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, rsp_valid_o,
         rsp_rdata_o, rsp_err_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got rdy%b sel%b en%b a%h w%b d%h v%b rd%h e%b cnt%0d",
               req_ready_o, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, rsp_valid_o,
               rsp_rdata_o, rsp_err_o, err_cnt_o);
    end
    pready_i = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready_o, psel_o, penable_o, rsp_valid_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_held: got rdy%b sel%b en%b v%b want 0",
               req_ready_o, psel_o, penable_o, rsp_valid_o);
    end
    rst = 1'b0;
    model_err_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({req_ready_o, rsp_valid_o, psel_o, err_cnt_o} !== {3'b100, 8'd0}) begin
        n_fail++;
        $display("FAIL reset_mid_after%0d: got rdy%b v%b sel%b cnt%0d want rdy1 v0 sel0 cnt0",
                 i, req_ready_o, rsp_valid_o, psel_o, err_cnt_o);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++)
      run_txn("saturate", 12'($urandom), 1'($urandom), $urandom, 0, 1'b1, $urandom, 0);
    n_cmp++;
    if (err_cnt_o !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate_final: got %0d want 255", err_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_wait_err();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_apb_master.md
CC_APB_MASTER -- requirements
Module: cc_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: consecutive ACCESS cycles with pready_i=0 before abort; 0 disables timeout; legal range 0..255.
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req_valid_i input 1 / req_ready_o output 1 / req_addr_i input 12 / req_write_i input 1 / req_wdata_i input 32 (request channel).
REQ-005 SHALL have ports: rsp_valid_o output 1 / rsp_ready_i input 1 / rsp_rdata_o output 32 / rsp_err_o output 1 (response channel).
REQ-006 SHALL have ports: psel_o output 1 / penable_o output 1 / paddr_o output 12 / pwrite_o output 1 / pwdata_o output 32 (APB master outputs, all registered).
REQ-007 SHALL have ports: pready_i input 1 / prdata_i input 32 / pslverr_i input 1 (APB slave returns, feeding the cache-controller config slave).
REQ-008 SHALL have port: err_cnt_o output 8, saturating count of responses with rsp_err_o=1.

Function
REQ-009 SHALL implement FSM with states IDLE, SETUP, ACCESS, RESP, one transaction in flight at a time.
REQ-010 SHALL drive req_ready_o=1 only in IDLE; a request is accepted on a cycle with req_valid_i=1 and req_ready_o=1.
REQ-011 On acceptance SHALL register addr/write/wdata to paddr_o/pwrite_o/pwdata_o and enter SETUP next cycle.
REQ-012 In SETUP SHALL drive psel_o=1, penable_o=0 for exactly one cycle, then enter ACCESS.
REQ-013 In ACCESS SHALL drive psel_o=1, penable_o=1; paddr_o/pwrite_o/pwdata_o SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-014 In ACCESS with pready_i=1 SHALL latch rsp_rdata_o=prdata_i for reads (0 for writes), rsp_err_o=pslverr_i, then enter RESP; psel_o/penable_o SHALL be 0 next cycle.
REQ-015 SHALL count consecutive ACCESS cycles with pready_i=0 in an 8-bit counter cleared on entering ACCESS; when TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES, SHALL abort: rsp_rdata_o=0, rsp_err_o=1, enter RESP, deassert psel_o/penable_o.
REQ-016 pready_i=1 on the same cycle the timeout would fire SHALL win (normal completion).
REQ-017 In RESP SHALL hold rsp_valid_o=1 and rsp_rdata_o/rsp_err_o stable until rsp_ready_i=1, then enter IDLE next cycle.
REQ-018 Latency with zero-wait slave: accept at cycle T, SETUP T+1, ACCESS T+2, rsp_valid_o=1 at T+3; earliest next accept at T+4 if rsp_ready_i=1 at T+3.
REQ-019 pslverr_i, prdata_i, pready_i SHALL be ignored outside ACCESS.
REQ-020 err_cnt_o SHALL increment by 1 on the RESP-exit handshake when rsp_err_o=1, saturating at 255 (no wrap).
REQ-021 req_* inputs SHALL be ignored when req_ready_o=0.

Reset
REQ-022 On rst=1 SHALL immediately (asynchronously) set state IDLE, psel_o=0, penable_o=0, paddr_o=0, pwrite_o=0, pwdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, err_cnt_o=0, timeout counter 0.
REQ-023 req_ready_o SHALL be 0 while rst=1 and 1 on the first clock after rst deasserts.
REQ-024 Reset asserted mid-transaction SHALL drop it without producing a response; no APB signal SHALL glitch high during reset.

Verification
REQ-025 Read addr 0x000 to config slave (pready=1, prdata=0x0001_0101 in ACCESS) -> psel 1 at T+1, penable 1 at T+2, rsp_valid at T+3 with rdata=0x0001_0101, err=0.
REQ-026 Write addr 0x004 data 0xDEAD_BEEF, pready low 3 ACCESS cycles then high with pslverr=1 -> paddr/pwdata stable 4 ACCESS cycles, rsp_rdata=0, rsp_err=1, err_cnt_o=1.
REQ-027 TIMEOUT_CYCLES=16, pready held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rdata=0, psel_o=0 next cycle; pready=1 on cycle 16 instead -> normal completion.
REQ-028 rsp_ready_i held 0 for 5 cycles -> rsp_valid/rdata/err stable, req_ready_o=0, new req_valid_i ignored; release -> IDLE next cycle.
REQ-029 rst pulsed during ACCESS -> all outputs 0 same cycle, no rsp_valid_o afterwards, req_ready_o=1 on first clock after release.
REQ-030 256 errored transactions -> err_cnt_o saturates at 255.
